// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB completer memory slice.
package apb_slave_pkg;

    localparam int APB_AW     = 8;
    localparam int APB_DW     = 8;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DW register storage: synchronous write, async clear, combinational read.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int DW    = APB_DW,
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next memory image: unchanged except for the addressed word when writing
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage registers, cleared as a whole by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer serving a local register file with configurable wait states.
// The caller has already range-checked nothing: out-of-range addresses are
// detected here against the full local address width and answered with PSLVERR.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int AW          = APB_AW,
    parameter int DW          = APB_DW,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [AW-1:0] PADDR,
    input  logic [DW-1:0] PWDATA,
    output logic          PREADY,
    output logic [DW-1:0] PRDATA,
    output logic          PSLVERR
);

    localparam int                    IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]           DEPTH_LIM = (AW + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  slverr_q, slverr_d;

    logic          setup_phase;
    logic          access_phase;
    logic          addr_ok;
    logic          begin_xfer;
    logic          enter_done;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [DW-1:0] rd_data;

    assign setup_phase  = PSEL & ~PENABLE;
    assign access_phase = PSEL & PENABLE;
    assign addr_ok      = {1'b0, PADDR} < DEPTH_LIM;
    assign mem_idx      = PADDR[IW-1:0];

    apb_slave_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_regfile (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we),
        .waddr (mem_idx),
        .wdata (PWDATA),
        .raddr (mem_idx),
        .rdata (rd_data)
    );

    // Next-state, wait counter, write strobe and registered response values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        rdata_d    = '0;
        slverr_d   = 1'b0;
        mem_we     = 1'b0;
        begin_xfer = 1'b0;
        enter_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    begin_xfer = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (setup_phase) begin
                    begin_xfer = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d      = '0;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (access_phase) begin
                    mem_we = PWRITE & addr_ok;
                end else if (setup_phase) begin
                    begin_xfer = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (begin_xfer) begin
            if (WAIT_CYCLES == 0) begin
                enter_done = 1'b1;
            end else begin
                state_d = ACCESS;
                cnt_d   = WAIT_LOAD;
            end
        end

        if (enter_done) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            slverr_d = ~addr_ok;
            rdata_d  = (!PWRITE && addr_ok) ? rd_data : '0;
        end
    end

    // State and response registers, cleared immediately by reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    assign PREADY  = ready_q;
    assign PRDATA  = rdata_q;
    assign PSLVERR = slverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances with 0, 2 and 3 wait states share
// one APB bus and are selected individually through their own PSEL line.
module tb_apb_slave_mem;

    localparam int DEPTH = 64;

    logic       PCLK;
    logic       PRESET;
    logic [2:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready  [3];
    logic [7:0] prdata  [3];
    logic       pslverr [3];

    logic [7:0] ref_mem [3][DEPTH];
    int         vectors;
    int         miscompares;

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut_w3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2])
    );

    // Free-running 10-unit clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Safety net so a stuck bench still ends with a visible report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int waitOf(input int idx);
        case (idx)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[d][a] = 8'h00;
            end
        end
    endtask

    task automatic idleBus();
        @(negedge PCLK);
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    // One complete transfer on instance idx; returns in the middle of the
    // PREADY cycle with the bus still held, so the commit edge follows.
    task automatic applyStimulus(input int idx, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        int         cyc;
        bit         seen;
        bit         exp_err;
        logic [7:0] exp_rd;
        @(negedge PCLK);
        psel      = 3'b000;
        psel[idx] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = wdata;
        checkOutput("setup_ready", 32'(pready[idx]), 32'd0);
        checkOutput("setup_rdata", 32'(prdata[idx]), 32'd0);
        exp_err = int'(addr) >= DEPTH;
        exp_rd  = (!wr && !exp_err) ? ref_mem[idx][addr[5:0]] : 8'h00;
        @(negedge PCLK);
        penable = 1'b1;
        seen    = 1'b0;
        cyc     = 0;
        while (!seen && cyc < 40) begin
            cyc++;
            if (cyc > 1) @(negedge PCLK);
            if (pready[idx] === 1'b1) seen = 1'b1;
        end
        checkOutput("ready_seen", 32'(seen), 32'd1);
        checkOutput("latency", 32'(cyc), 32'(waitOf(idx) + 1));
        checkOutput("rdata", 32'(prdata[idx]), 32'(exp_rd));
        checkOutput("slverr", 32'(pslverr[idx]), 32'(exp_err));
        if (wr && !exp_err) ref_mem[idx][addr[5:0]] = wdata;
    endtask

    // Directed scenarios followed by randomized traffic against the model
    initial begin
        vectors     = 0;
        miscompares = 0;
        clearModel();
        PRESET  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;

        repeat (2) @(negedge PCLK);
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset_ready", 32'(pready[d]), 32'd0);
            checkOutput("reset_rdata", 32'(prdata[d]), 32'd0);
            checkOutput("reset_slverr", 32'(pslverr[d]), 32'd0);
        end
        PRESET = 1'b0;

        $display("[TB] read after reset, zero wait states");
        applyStimulus(0, 1'b0, 8'h05, 8'h00);
        idleBus();

        $display("[TB] write then read with three wait states");
        applyStimulus(2, 1'b1, 8'h10, 8'hA5);
        idleBus();
        applyStimulus(2, 1'b0, 8'h10, 8'h00);
        idleBus();

        $display("[TB] back-to-back write/read");
        applyStimulus(0, 1'b1, 8'h01, 8'h11);
        applyStimulus(0, 1'b0, 8'h01, 8'h00);
        applyStimulus(2, 1'b1, 8'h01, 8'h5A);
        applyStimulus(2, 1'b0, 8'h01, 8'h00);
        idleBus();

        $display("[TB] out-of-range write and read");
        applyStimulus(0, 1'b1, 8'h40, 8'h3C);
        idleBus();
        applyStimulus(0, 1'b0, 8'h40, 8'h00);
        applyStimulus(0, 1'b0, 8'hFF, 8'h00);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 1'b0, 8'(a), 8'h00);
        end
        idleBus();

        $display("[TB] enable without setup is ignored");
        @(negedge PCLK);
        psel    = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h07;
        pwdata  = 8'h99;
        repeat (3) begin
            @(negedge PCLK);
            checkOutput("noset_ready", 32'(pready[0]), 32'd0);
        end
        idleBus();
        applyStimulus(0, 1'b0, 8'h07, 8'h00);
        idleBus();

        $display("[TB] abort during access");
        @(negedge PCLK);
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h02;
        pwdata  = 8'hFF;
        @(negedge PCLK);
        penable = 1'b1;
        checkOutput("abort_acc1", 32'(pready[1]), 32'd0);
        @(negedge PCLK);
        checkOutput("abort_acc2", 32'(pready[1]), 32'd0);
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge PCLK);
        checkOutput("abort_after", 32'(pready[1]), 32'd0);
        applyStimulus(1, 1'b0, 8'h02, 8'h00);
        idleBus();

        $display("[TB] reset in the middle of an access");
        @(negedge PCLK);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h03;
        pwdata  = 8'h77;
        @(negedge PCLK);
        penable = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(pready[2]), 32'd0);
        checkOutput("rst_rdata", 32'(prdata[2]), 32'd0);
        checkOutput("rst_slverr", 32'(pslverr[2]), 32'd0);
        psel    = 3'b000;
        penable = 1'b0;
        clearModel();
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        applyStimulus(2, 1'b0, 8'h03, 8'h00);
        applyStimulus(2, 1'b0, 8'h10, 8'h00);
        applyStimulus(0, 1'b0, 8'h01, 8'h00);
        idleBus();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 120; n++) begin
            int         idx;
            bit         wr;
            logic [7:0] addr;
            idx  = int'($urandom_range(0, 2));
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            applyStimulus(idx, wr, addr, 8'($urandom));
            if ($urandom_range(0, 1) == 1) idleBus();
        end
        idleBus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
